// File: rtl/mem_arbiter_pkg.sv
// Shared types for the icache/dcache memory arbiter.
// Commands, tags, owner ids and tag-table entry layout.
package mem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int BLOCK_W = 64;
  localparam int MEM_TAG_W = 4;
  localparam int NUM_MEM_TAGS = 1 << MEM_TAG_W;
  localparam int MEM_STARVE_LIMIT = 8;

  typedef logic [ADDR_W-1:0] ADDR;
  typedef logic [BLOCK_W-1:0] MEM_BLOCK;
  typedef logic [MEM_TAG_W-1:0] MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    logic     valid;
    MEM_OWNER owner;
  } MEM_TAG_ENTRY;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the caches, the arbiter and memory.
// master: arbiter view; slave: caches + memory view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  MEM_COMMAND icache_command;
  ADDR        icache_addr;
  MEM_COMMAND dcache_command;
  ADDR        dcache_addr;
  MEM_BLOCK   dcache_data;

  MEM_TAG     mem2proc_transaction_tag;
  MEM_BLOCK   mem2proc_data;
  MEM_TAG     mem2proc_data_tag;

  MEM_COMMAND proc2mem_command;
  ADDR        proc2mem_addr;
  MEM_BLOCK   proc2mem_data;

  MEM_TAG     icache_trans_tag;
  MEM_TAG     dcache_trans_tag;
  MEM_BLOCK   icache_resp_data;
  MEM_TAG     icache_resp_tag;
  MEM_BLOCK   dcache_resp_data;
  MEM_TAG     dcache_resp_tag;
  logic       spurious_resp;

  modport master (
    input  icache_command, icache_addr,
    input  dcache_command, dcache_addr,
    input  dcache_data,
    input  mem2proc_transaction_tag,
    input  mem2proc_data, mem2proc_data_tag,
    output proc2mem_command, proc2mem_addr,
    output proc2mem_data,
    output icache_trans_tag, dcache_trans_tag,
    output icache_resp_data, icache_resp_tag,
    output dcache_resp_data, dcache_resp_tag,
    output spurious_resp
  );

  modport slave (
    output icache_command, icache_addr,
    output dcache_command, dcache_addr,
    output dcache_data,
    output mem2proc_transaction_tag,
    output mem2proc_data, mem2proc_data_tag,
    input  proc2mem_command, proc2mem_addr,
    input  proc2mem_data,
    input  icache_trans_tag, dcache_trans_tag,
    input  icache_resp_data, icache_resp_tag,
    input  dcache_resp_data, dcache_resp_tag,
    input  spurious_resp
  );

endinterface

// File: rtl/mem_tag_table.sv
// Owner table indexed by memory tag: one write, one read/clear port.
// Ports: clock, reset (async low), wr_*, rd_tag, clr_en, rd_entry.
module mem_tag_table
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         wr_en,
  input  MEM_TAG       wr_tag,
  input  MEM_OWNER     wr_owner,
  input  MEM_TAG       rd_tag,
  input  logic         clr_en,
  output MEM_TAG_ENTRY rd_entry
);

  MEM_TAG_ENTRY entries [NUM_TAGS];

  assign rd_entry = entries[rd_tag];

  // Clear is applied before the write so a tag that is
  // retired and reissued in the same cycle keeps the new owner.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries <= '{default: '0};
    end else begin
      if (clr_en)
        entries[rd_tag].valid <= 1'b0;
      if (wr_en)
        entries[wr_tag] <= '{valid: 1'b1, owner: wr_owner};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between icache and dcache, tracks tag owners.
// Ports: clock, reset (async low), bus (mem_arbiter_if.master).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = MEM_STARVE_LIMIT,
  parameter int NUM_TAGS     = NUM_MEM_TAGS
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          spurious_q;

  logic          i_req;
  logic          d_req;
  logic          starved;
  logic          grant_i;
  logic          grant_d;
  logic          accepted;
  logic          i_acc;
  MEM_COMMAND    cmd;
  MEM_TAG        mem_tag;
  MEM_TAG        rsp_tag;
  MEM_TAG_ENTRY  rsp_entry;
  logic          hit;
  logic          miss;
  logic          tbl_wr;
  MEM_OWNER      tbl_owner;

  always_comb begin
    i_req   = bus.icache_command != MEM_NONE;
    d_req   = bus.dcache_command != MEM_NONE;
    starved = starve_cnt == LIMIT;
    grant_i = reset && i_req &&
              (!d_req || starved);
    grant_d = reset && d_req && !grant_i;
    mem_tag = bus.mem2proc_transaction_tag;

    cmd = MEM_NONE;
    unique case (1'b1)
      grant_i: cmd = bus.icache_command;
      grant_d: cmd = bus.dcache_command;
      default: cmd = MEM_NONE;
    endcase

    accepted  = (grant_i || grant_d) &&
                mem_tag != '0;
    i_acc     = grant_i && mem_tag != '0;
    tbl_wr    = accepted && cmd == MEM_LOAD;
    tbl_owner = grant_i ? OWNER_ICACHE
                        : OWNER_DCACHE;

    rsp_tag = bus.mem2proc_data_tag;
    hit  = reset && rsp_tag != '0 &&
           rsp_entry.valid;
    miss = reset && rsp_tag != '0 &&
           !rsp_entry.valid;
  end

  always_comb begin
    bus.proc2mem_command = cmd;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    if (grant_i)
      bus.proc2mem_addr = bus.icache_addr;
    if (grant_d)
      bus.proc2mem_addr = bus.dcache_addr;
    if (grant_d && cmd == MEM_STORE)
      bus.proc2mem_data = bus.dcache_data;

    bus.icache_trans_tag = grant_i ? mem_tag : '0;
    bus.dcache_trans_tag = grant_d ? mem_tag : '0;

    bus.icache_resp_tag  = '0;
    bus.icache_resp_data = '0;
    bus.dcache_resp_tag  = '0;
    bus.dcache_resp_data = '0;
    if (hit && rsp_entry.owner == OWNER_ICACHE) begin
      bus.icache_resp_tag  = rsp_tag;
      bus.icache_resp_data = bus.mem2proc_data;
    end
    if (hit && rsp_entry.owner == OWNER_DCACHE) begin
      bus.dcache_resp_tag  = rsp_tag;
      bus.dcache_resp_data = bus.mem2proc_data;
    end

    bus.spurious_resp = reset && spurious_q;
  end

  // A rejected icache request (lost arbitration or tag 0)
  // counts as a starved cycle; any acceptance or idle resets.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (miss)
        spurious_q <= 1'b1;
      if (!i_req || i_acc)
        starve_cnt <= '0;
      else if (!starved)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  mem_tag_table #(
    .NUM_TAGS (NUM_TAGS)
  ) u_table (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (tbl_wr),
    .wr_tag   (mem_tag),
    .wr_owner (tbl_owner),
    .rd_tag   (rsp_tag),
    .clr_en   (hit),
    .rd_entry (rsp_entry)
  );

endmodule
